// File: rtl/tile_array_writer.sv
// Writable 8x8 tile map: 2-bit cells, req/ack single-cell writes,
// sequenced whole-map fill and a live collectible-tile count.
module tile_array_writer #(
  parameter logic [1:0] COLLECT_TYPE = 2'b01
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [2:0] Xnum,
  input  logic [2:0] Ynum,
  output logic [1:0] Tile_Type,
  input  logic       wr_req,
  input  logic [2:0] wr_X,
  input  logic [2:0] wr_Y,
  input  logic [1:0] wr_type,
  output logic       wr_ack,
  input  logic       fill_req,
  input  logic [1:0] fill_type,
  output logic       busy,
  output logic       fill_done,
  output logic [6:0] collect_cnt,
  output logic       all_clear
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  // Row 7, columns 0..5 hold type 01; everything else is 00.
  localparam logic [63:0][1:0] RST_MAP = {16'h0555, 112'h0};

  localparam logic [6:0] RST_CNT =
    (COLLECT_TYPE == 2'b01) ? 7'd6  :
    (COLLECT_TYPE == 2'b00) ? 7'd58 : 7'd0;

  state_e           state_q, state_d;
  logic [5:0]       addr_q, addr_d;
  logic [63:0][1:0] cells_q, cells_d;
  logic [6:0]       cnt_q, cnt_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;

  logic [5:0]       wr_idx;
  logic [1:0]       old_type;
  logic             inc, dec;

  assign wr_idx   = {wr_Y, wr_X};
  assign old_type = cells_q[wr_idx];
  assign inc = (old_type != COLLECT_TYPE) &&
               (wr_type == COLLECT_TYPE);
  assign dec = (old_type == COLLECT_TYPE) &&
               (wr_type != COLLECT_TYPE);

  // State, map, count and pulse registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cells_q <= RST_MAP;
      cnt_q   <= RST_CNT;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cells_q <= cells_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  // Next state and fill address sequencing.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (fill_req) begin
          state_d = FILL;
          addr_d  = '0;
        end
      end
      FILL: begin
        addr_d = addr_q + 6'd1;
        if (addr_q == 6'd63) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Cell writes, count update and pulse generation.
  always_comb begin
    cells_d = cells_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fill_req) begin
          cnt_d = '0;
        end else if (wr_req) begin
          cells_d[wr_idx] = wr_type;
          ack_d = 1'b1;
          unique case (1'b1)
            inc:     cnt_d = cnt_q + 7'd1;
            dec:     cnt_d = cnt_q - 7'd1;
            default: cnt_d = cnt_q;
          endcase
        end
      end
      FILL: begin
        cells_d[addr_q] = fill_type;
        if (fill_type == COLLECT_TYPE) begin
          cnt_d = cnt_q + 7'd1;
        end
        if (addr_q == 6'd63) begin
          done_d = 1'b1;
        end
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  assign Tile_Type   = cells_q[{Ynum, Xnum}];
  assign busy        = (state_q == FILL);
  assign wr_ack      = ack_q;
  assign fill_done   = done_q;
  assign collect_cnt = cnt_q;
  assign all_clear   = (cnt_q == 7'd0) && !busy;

endmodule

// File: tb/tb_tile_array_writer.sv
// Self-checking bench for tile_array_writer: directed vector table,
// fill/reset corner sequences and random writes against a map model.
module tb_tile_array_writer;

  logic       clk = 1'b0;
  logic       resetN;
  logic [2:0] Xnum, Ynum;
  logic [1:0] Tile_Type;
  logic       wr_req;
  logic [2:0] wr_X, wr_Y;
  logic [1:0] wr_type;
  logic       wr_ack;
  logic       fill_req;
  logic [1:0] fill_type;
  logic       busy;
  logic       fill_done;
  logic [6:0] collect_cnt;
  logic       all_clear;

  always #5 clk = ~clk;

  tile_array_writer dut (
    .clk(clk),
    .resetN(resetN),
    .Xnum(Xnum),
    .Ynum(Ynum),
    .Tile_Type(Tile_Type),
    .wr_req(wr_req),
    .wr_X(wr_X),
    .wr_Y(wr_Y),
    .wr_type(wr_type),
    .wr_ack(wr_ack),
    .fill_req(fill_req),
    .fill_type(fill_type),
    .busy(busy),
    .fill_done(fill_done),
    .collect_cnt(collect_cnt),
    .all_clear(all_clear)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] mem [64];

  typedef struct {
    logic [2:0] x;
    logic [2:0] y;
    logic [1:0] t;
    int         cnt;
    logic       clr;
  } vec_t;

  vec_t tv [8];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int mcnt();
    int c = 0;
    for (int i = 0; i < 64; i++) begin
      if (mem[i] == 2'b01) c++;
    end
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      mem[i] = (i >= 56 && i <= 61) ? 2'b01 : 2'b00;
    end
  endtask

  task automatic rd_check(input logic [2:0] x,
                          input logic [2:0] y,
                          input string name);
    Xnum = x;
    Ynum = y;
    #1;
    check(name, 32'(Tile_Type), 32'(mem[{y, x}]));
  endtask

  // Write one cell; mem must already hold the new value.
  task automatic do_write(input logic [2:0] x,
                          input logic [2:0] y,
                          input logic [1:0] t,
                          input string name);
    int ec;
    ec = mcnt();
    wr_X = x;
    wr_Y = y;
    wr_type = t;
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    check({name, "_ack"}, 32'(wr_ack), 32'd1);
    check({name, "_cnt"}, 32'(collect_cnt), 32'(ec));
    check({name, "_clr"}, 32'(all_clear), 32'(ec == 0));
    rd_check(x, y, {name, "_rd"});
    step();
    check({name, "_ack_off"}, 32'(wr_ack), 32'd0);
  endtask

  // Run a whole fill; optional injection of wr_req and fill_req
  // in the middle, or a simultaneous wr_req at the start.
  task automatic run_fill(input logic [1:0] t,
                          input bit inject,
                          input bit simul,
                          output int bcyc,
                          output int dones,
                          output int acks);
    int guard;
    bcyc = 0;
    dones = 0;
    acks = 0;
    guard = 0;
    fill_type = t;
    fill_req = 1'b1;
    if (simul) begin
      wr_X = 3'd7;
      wr_Y = 3'd7;
      wr_type = 2'b10;
      wr_req = 1'b1;
    end
    step();
    fill_req = 1'b0;
    wr_req = 1'b0;
    while (busy === 1'b1 && guard < 200) begin
      bcyc++;
      guard++;
      if (wr_ack) acks++;
      if (fill_done) dones++;
      if (inject && bcyc == 40) begin
        wr_X = 3'd3;
        wr_Y = 3'd0;
        wr_type = 2'b10;
        wr_req = 1'b1;
        fill_req = 1'b1;
      end
      if (inject && bcyc == 45) begin
        wr_req = 1'b0;
        fill_req = 1'b0;
      end
      step();
    end
    wr_req = 1'b0;
    fill_req = 1'b0;
    if (wr_ack) acks++;
    if (fill_done) dones++;
    for (int i = 0; i < 4; i++) begin
      step();
      if (fill_done) dones++;
      if (busy) bcyc += 1000;
    end
    for (int i = 0; i < 64; i++) mem[i] = t;
  endtask

  int bc, dn, ak;
  int rd_busy, rd_done;
  logic [2:0] rx, ry, qx, qy;
  logic [1:0] rt;

  initial begin
    resetN = 1'b0;
    Xnum = '0;
    Ynum = '0;
    wr_req = 1'b0;
    wr_X = '0;
    wr_Y = '0;
    wr_type = '0;
    fill_req = 1'b0;
    fill_type = '0;
    model_reset();

    tv[0] = '{3'd2, 3'd7, 2'b00, 5, 1'b0};
    tv[1] = '{3'd0, 3'd7, 2'b00, 4, 1'b0};
    tv[2] = '{3'd1, 3'd7, 2'b00, 3, 1'b0};
    tv[3] = '{3'd3, 3'd7, 2'b00, 2, 1'b0};
    tv[4] = '{3'd4, 3'd7, 2'b00, 1, 1'b0};
    tv[5] = '{3'd5, 3'd7, 2'b00, 0, 1'b1};
    tv[6] = '{3'd4, 3'd3, 2'b01, 1, 1'b0};
    tv[7] = '{3'd4, 3'd3, 2'b01, 1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    resetN = 1'b1;
    step();

    // Reset state
    check("rst_cnt", 32'(collect_cnt), 32'd6);
    check("rst_clr", 32'(all_clear), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(wr_ack), 32'd0);
    check("rst_done", 32'(fill_done), 32'd0);
    for (int x = 0; x < 8; x++) begin
      rd_check(3'(x), 3'd7, "rst_row7");
    end
    rd_check(3'd0, 3'd0, "rst_y0x0");

    // Directed write table
    for (int i = 0; i < 8; i++) begin
      mem[{tv[i].y, tv[i].x}] = tv[i].t;
      do_write(tv[i].x, tv[i].y, tv[i].t, $sformatf("tv%0d", i));
      check($sformatf("tv%0d_cnt_tab", i),
            32'(collect_cnt), 32'(tv[i].cnt));
      check($sformatf("tv%0d_clr_tab", i),
            32'(all_clear), 32'(tv[i].clr));
    end

    // Full fill with collectibles
    run_fill(2'b01, 1'b0, 1'b0, bc, dn, ak);
    check("fill1_busy_cycles", 32'(bc), 32'd64);
    check("fill1_dones", 32'(dn), 32'd1);
    check("fill1_cnt", 32'(collect_cnt), 32'd64);
    check("fill1_clr", 32'(all_clear), 32'd0);
    for (int i = 0; i < 64; i++) begin
      rd_check(3'(i % 8), 3'(i / 8), "fill1_cell");
    end

    // Exact fill_done timing: pulse in cycle 65 only
    fill_type = 2'b01;
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    check("fill2_cnt_clear", 32'(collect_cnt), 32'd0);
    repeat (63) step();
    check("fill2_busy_c64", 32'(busy), 32'd1);
    check("fill2_done_c64", 32'(fill_done), 32'd0);
    step();
    check("fill2_busy_c65", 32'(busy), 32'd0);
    check("fill2_done_c65", 32'(fill_done), 32'd1);
    step();
    check("fill2_done_c66", 32'(fill_done), 32'd0);
    check("fill2_cnt", 32'(collect_cnt), 32'd64);

    // Simultaneous fill_req and wr_req in IDLE
    run_fill(2'b00, 1'b0, 1'b1, bc, dn, ak);
    check("simul_acks", 32'(ak), 32'd0);
    check("simul_busy_cycles", 32'(bc), 32'd64);
    check("simul_dones", 32'(dn), 32'd1);
    check("simul_cnt", 32'(collect_cnt), 32'd0);
    check("simul_clr", 32'(all_clear), 32'd1);
    rd_check(3'd7, 3'd7, "simul_cell");

    // wr_req and fill_req during FILL are ignored
    run_fill(2'b11, 1'b1, 1'b0, bc, dn, ak);
    check("inj_acks", 32'(ak), 32'd0);
    check("inj_busy_cycles", 32'(bc), 32'd64);
    check("inj_dones", 32'(dn), 32'd1);
    rd_check(3'd3, 3'd0, "inj_cell");
    check("inj_cnt", 32'(collect_cnt), 32'd0);

    // Reset in the middle of a fill
    fill_type = 2'b10;
    fill_req = 1'b1;
    step();
    fill_req = 1'b0;
    repeat (30) step();
    check("midrst_busy_pre", 32'(busy), 32'd1);
    resetN = 1'b0;
    #1;
    model_reset();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cnt", 32'(collect_cnt), 32'd6);
    rd_check(3'd0, 3'd0, "midrst_y0x0");
    rd_check(3'd5, 3'd2, "midrst_y2x5");
    rd_check(3'd0, 3'd7, "midrst_y7x0");
    rd_check(3'd6, 3'd7, "midrst_y7x6");
    step();
    resetN = 1'b1;
    rd_busy = 0;
    rd_done = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (busy) rd_busy++;
      if (fill_done) rd_done++;
    end
    check("midrst_no_busy", 32'(rd_busy), 32'd0);
    check("midrst_no_done", 32'(rd_done), 32'd0);
    check("midrst_cnt_after", 32'(collect_cnt), 32'd6);

    // Random writes and occasional fills against the map model
    for (int n = 0; n < 300; n++) begin
      if (n % 100 == 99) begin
        rt = 2'($urandom_range(0, 3));
        run_fill(rt, 1'b0, 1'b0, bc, dn, ak);
        check("rnd_fill_dones", 32'(dn), 32'd1);
        check("rnd_fill_cnt", 32'(collect_cnt), 32'(mcnt()));
      end else begin
        rx = 3'($urandom_range(0, 7));
        ry = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) rt = 2'b01;
        else rt = 2'($urandom_range(0, 3));
        mem[{ry, rx}] = rt;
        do_write(rx, ry, rt, "rnd_wr");
        qx = 3'($urandom_range(0, 7));
        qy = 3'($urandom_range(0, 7));
        rd_check(qx, qy, "rnd_rd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tile_array_writer.md
Name: tile_array_writer

Overview:
Writable 8x8 tile map holding one 2-bit tile type per cell. It is the write-side counterpart of the read-only tile lookup.
- Game logic reads cells combinationally by Xnum/Ynum.
- Game logic updates single cells through a req/ack write port, e.g. to erase a collected tile.
- A sequenced fill rewrites the whole map for a level restart.
- It keeps a live count of collectible tiles and flags when the level is cleared.

Parameters:
COLLECT_TYPE, 2'b01, tile type counted as collectible.

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
Xnum  in  3  read column
Ynum  in  3  read row
Tile_Type  out  2  tile type at (Ynum, Xnum)
wr_req  in  1  single-cell write request
wr_X  in  3  write column
wr_Y  in  3  write row
wr_type  in  2  new tile type
wr_ack  out  1  one-cycle pulse: write committed
fill_req  in  1  start full-map fill
fill_type  in  2  type written to every cell during fill
busy  out  1  fill in progress
fill_done  out  1  one-cycle pulse after last fill write
collect_cnt  out  7  number of cells equal to COLLECT_TYPE (0..64)
all_clear  out  1  collect_cnt==0 and not busy

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on resetN.
- Storage: 64 cells of 2 bits. Cell index = {Y, X}.
- Reset values:
  - All cells 2'b00, except row 7, columns 0..5, which are 2'b01.
  - collect_cnt=6 (at default COLLECT_TYPE).
  - wr_ack=0, busy=0, fill_done=0. all_clear=0 follows.
  - FSM in IDLE, fill address 0.
- Read port: Tile_Type = cell[Ynum][Xnum], purely combinational from stored cells. A write committed at edge N is visible on Tile_Type after edge N.
- FSM states: IDLE and FILL.
- IDLE:
  - If fill_req=1: go to FILL and set fill address to 0. collect_cnt is cleared to 0 at this same edge. Any wr_req in this cycle is ignored and not acked, because fill has priority.
  - Else if wr_req=1: write wr_type to cell[wr_Y][wr_X] at the edge. wr_ack=1 for the following cycle only.
  - Count update on a write:
    - +1 if old!=COLLECT_TYPE and wr_type==COLLECT_TYPE.
    - -1 if old==COLLECT_TYPE and wr_type!=COLLECT_TYPE.
    - Unchanged otherwise, including a rewrite with the same type.
  - A held wr_req writes and acks on every cycle; writes are idempotent. The requester drops wr_req after seeing wr_ack.
- FILL:
  - Each cycle writes fill_type to cell[addr[5:3]][addr[2:0]], with addr running 0..63. collect_cnt +1 per write when fill_type==COLLECT_TYPE.
  - busy=1 in every FILL cycle.
  - After the write at addr 63: return to IDLE, busy=0, fill_done=1 for one cycle.
  - Total fill latency is 64 cycles from the fill_req edge to the last write. fill_done is asserted in the 65th cycle.
  - wr_req is ignored in FILL (no write, no ack). fill_req is ignored in FILL (no restart).
  - fill_type is sampled every cycle and must be held stable by the requester.
- Reads during FILL return a mix of new and old cells, by address order.
- collect_cnt width is 7 bits. It never wraps; the range 0..64 is guaranteed by construction.
- all_clear is combinational: (collect_cnt==0) && !busy.
- Reset mid-fill restores the reset map, count 6 and IDLE immediately. No fill_done is produced.

Test Plan:
1. Reset release: read (Y7,X0..5) -> 2'b01; (Y7,X6), (Y0,X0) -> 2'b00; collect_cnt=6; all_clear=0; busy=0.
2. Write (Y7,X2)=2'b00 with wr_req held one cycle -> wr_ack high for exactly one cycle; Tile_Type at (7,2)=00 the next cycle; collect_cnt=5.
3. Write 2'b00 to all six collectibles -> collect_cnt=0, all_clear=1. Then write 2'b01 at (3,4) -> collect_cnt=1, all_clear=0. Then rewrite 2'b01 at (3,4) -> collect_cnt stays 1 and wr_ack pulses.
4. fill_req with fill_type=2'b01 -> busy high for 64 cycles; fill_done pulses once in cycle 65; every cell reads 01; collect_cnt=64.
5. wr_req asserted during FILL and fill_req asserted again during FILL -> no wr_ack, target cell holds fill_type after completion, only one fill_done. Simultaneous fill_req and wr_req in IDLE -> fill starts and there is no wr_ack.
6. Assert resetN=0 at fill addr 30 with fill_type=2'b10 -> map returns to reset pattern, collect_cnt=6, busy=0, and no fill_done after release.
